sseg_scan_mux: RTL and testbench

- Time-multiplexed scan driver for an NUM_DIGITS-digit common-anode seven-segment display.
- Sits directly upstream of SSEG_Decoder. Presents one 4-bit digit on digit_num, which feeds the decoder's Num input.
- Drives the matching active-low anode line.
- Frame-synchronous double buffering, so a new value never tears mid-scan.

---
 rtl/sseg_pkg.sv | 7 +
 rtl/sseg_refresh_timer.sv | 18 +
 rtl/sseg_scan_mux.sv | 92 +++++++++
 tb/tb_sseg_scan_mux.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared constants and types for the seven-segment scan driver.
package sseg_pkg;
    localparam int SSEG_DIGIT_W = 4;
    localparam logic ANODE_ON  = 1'b0;
    localparam logic ANODE_OFF = 1'b1;
    typedef logic [SSEG_DIGIT_W-1:0] digit_t;
endpackage

// File: rtl/sseg_refresh_timer.sv
// Slot prescaler: counts 0..REFRESH_DIV-1 and flags the last cycle of each slot.
module sseg_refresh_timer #(
    parameter int REFRESH_DIV = 50000,
    localparam int CNT_W = $clog2(REFRESH_DIV)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] cnt,
    output logic             tick
);
    assign tick = (cnt == CNT_W'(REFRESH_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst)       cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/sseg_scan_mux.sv
// Multiplexed common-anode scan driver with frame-synchronous double buffering.
// Optional leading-zero blanking: define SSEG_LEADING_ZERO_BLANK_EN.
module sseg_scan_mux
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [SSEG_DIGIT_W*NUM_DIGITS-1:0] value_in,
    input  logic                               load,
    output digit_t                             digit_num,
    output logic [NUM_DIGITS-1:0]              anode,
    output logic                               frame_done
);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VAL_W = SSEG_DIGIT_W * NUM_DIGITS;

    logic [CNT_W-1:0]      cnt;
    logic                  tick;
    logic [IDX_W-1:0]      idx;
    logic [VAL_W-1:0]      pend;
    logic                  pend_v;
    logic [VAL_W-1:0]      disp;
    logic                  boundary;
    logic                  blank;
    logic [NUM_DIGITS-1:0] show;

    sseg_refresh_timer #(
        .REFRESH_DIV(REFRESH_DIV)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .cnt (cnt),
        .tick(tick)
    );

    assign boundary = tick && (idx == IDX_W'(NUM_DIGITS - 1));
    assign blank    = (32'(cnt) < BLANK_CYCLES);

    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= '0;
            pend       <= '0;
            pend_v     <= 1'b0;
            disp       <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= boundary;
            if (tick)
                idx <= boundary ? '0 : idx + 1'b1;
            // A load on the boundary edge bypasses pend so it shows from digit 0.
            if (boundary) begin
                if (load)        disp <= value_in;
                else if (pend_v) disp <= pend;
                pend_v <= 1'b0;
            end else if (load) begin
                pend   <= value_in;
                pend_v <= 1'b1;
            end
        end
    end

`ifdef SSEG_LEADING_ZERO_BLANK_EN
    always_comb begin
        logic seen;
        seen = 1'b0;
        show = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            seen    = seen | (disp[k*SSEG_DIGIT_W +: SSEG_DIGIT_W] != '0);
            show[k] = seen || (k == 0);
        end
    end
`else
    assign show = '1;
`endif

    always_comb begin
        digit_num = '0;
        anode     = {NUM_DIGITS{ANODE_OFF}};
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                digit_num = disp[k*SSEG_DIGIT_W +: SSEG_DIGIT_W];
                if (!blank && show[k])
                    anode[k] = ANODE_ON;
            end
        end
    end
endmodule

// File: tb/tb_sseg_scan_mux.sv
// Self-checking bench for sseg_scan_mux against a frame-level reference model.
module tb_sseg_scan_mux;
    localparam int N   = 4;
    localparam int DIV = 4;
    localparam int BLK = 1;
    localparam int FRAME = N * DIV;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [15:0]   value_in = '0;
    logic          load = 1'b0;
    logic [3:0]    digit_num;
    logic [N-1:0]  anode;
    logic          frame_done;

    int checks = 0;
    int errors = 0;

    int          t;
    logic [15:0] m_disp, m_pend;
    logic        m_pend_v, m_fd;

    sseg_scan_mux #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (DIV),
        .BLANK_CYCLES(BLK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .value_in  (value_in),
        .load      (load),
        .digit_num (digit_num),
        .anode     (anode),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic model_edge(input logic r, input logic l, input logic [15:0] v);
        if (r) begin
            t = 0; m_disp = '0; m_pend = '0; m_pend_v = 0; m_fd = 0;
        end else begin
            m_fd = (t % FRAME == FRAME - 1);
            if (m_fd) begin
                if (l) m_disp = v;
                else if (m_pend_v) m_disp = m_pend;
                m_pend_v = 0;
            end else if (l) begin
                m_pend = v; m_pend_v = 1;
            end
            t++;
        end
    endtask

    task automatic check_outputs();
        int slot, c;
        logic [3:0]   exp_d;
        logic [N-1:0] exp_a;
        logic         lit;
        slot  = (t / DIV) % N;
        c     = t % DIV;
        exp_d = 4'((m_disp >> (4 * slot)) & 16'hF);
        lit   = (c >= BLK);
`ifdef SSEG_LEADING_ZERO_BLANK_EN
        if (slot > 0 && (m_disp >> (4 * slot)) == 0) lit = 0;
`endif
        exp_a = lit ? N'(~(1 << slot)) : '1;
        checks++;
        assert (digit_num === exp_d) else begin
            errors++;
            $error("FAIL digit_num t=%0d got %h exp %h", t, digit_num, exp_d);
        end
        checks++;
        assert (anode === exp_a) else begin
            errors++;
            $error("FAIL anode t=%0d got %b exp %b", t, anode, exp_a);
        end
        checks++;
        assert (frame_done === m_fd) else begin
            errors++;
            $error("FAIL frame_done t=%0d got %b exp %b", t, frame_done, m_fd);
        end
    endtask

    task automatic step(input logic r, input logic l, input logic [15:0] v);
        rst = r; load = l; value_in = v;
        @(posedge clk);
        model_edge(r, l, v);
        #1;
        check_outputs();
        rst = 0; load = 0;
    endtask

    task automatic idle_until(input int phase);
        while (t % FRAME != phase) step(0, 0, 16'h0);
    endtask

    initial begin
        t = 0; m_disp = '0; m_pend = '0; m_pend_v = 0; m_fd = 0;

        step(1, 0, 16'h0);
        step(1, 0, 16'h0);
        checks++;
        assert (anode === 4'b1111) else begin
            errors++; $error("FAIL reset_anode got %b exp %b", anode, 4'b1111);
        end
        checks++;
        assert (digit_num === 4'h0) else begin
            errors++; $error("FAIL reset_digit got %h exp %h", digit_num, 4'h0);
        end

        for (int i = 0; i < 3; i++) step(0, 0, 16'h0);
        step(0, 1, 16'h1234);
        idle_until(0);
        checks++;
        assert (frame_done === 1'b1) else begin
            errors++; $error("FAIL first_frame_done got %b exp 1", frame_done);
        end
        for (int i = 0; i < FRAME; i++) step(0, 0, 16'h0);

        step(0, 1, 16'h1111);
        step(0, 0, 16'h0);
        step(0, 1, 16'h2222);
        idle_until(0);
        for (int i = 0; i < FRAME; i++) begin
            step(0, 0, 16'h0);
            checks++;
            assert (digit_num === 4'h2) else begin
                errors++; $error("FAIL newest_wins got %h exp %h", digit_num, 4'h2);
            end
        end

        idle_until(FRAME - 1);
        step(0, 1, 16'hABCD);
        checks++;
        assert (digit_num === 4'hD) else begin
            errors++; $error("FAIL bypass got %h exp %h", digit_num, 4'hD);
        end
        for (int i = 0; i < FRAME; i++) step(0, 0, 16'h0);

        idle_until(2);
        step(0, 1, 16'h5678);
        idle_until(9);
        step(1, 0, 16'h0);
        checks++;
        assert (anode === 4'b1111 && digit_num === 4'h0) else begin
            errors++; $error("FAIL midscan_rst got %b/%h exp 1111/0", anode, digit_num);
        end
        for (int i = 0; i < 2 * FRAME; i++) step(0, 0, 16'h0);

`ifdef SSEG_LEADING_ZERO_BLANK_EN
        step(0, 1, 16'h0042);
        for (int i = 0; i < 4 * FRAME; i++) step(0, 0, 16'h0);
        step(0, 1, 16'h0000);
        for (int i = 0; i < 2 * FRAME; i++) step(0, 0, 16'h0);
`endif

        for (int i = 0; i < 600; i++) begin
            logic [15:0] v;
            logic [15:0] mask;
            v = 16'($urandom);
            mask = 16'hFFFF >> (4 * $urandom_range(0, 3));
            v = v & mask;
            step($urandom_range(0, 150) == 0, $urandom_range(0, 7) == 0, v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
